// File: rtl/library_pkg.sv
// Shared constants, state encodings and address packing for the library SRAM
// arbiter and its slot table.
package library_pkg;

    localparam int N_SLOT  = 26;
    localparam int SLOT_AW = 10;
    localparam int ADDR_W  = 20;
    localparam int SLOT_W  = 5;
    localparam int LEN_W   = SLOT_AW + 1;
    localparam int COORD_W = 5;
    localparam int DATA_W  = 2 * COORD_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REC  = 1'b1
    } st_state_e;

    typedef enum logic [1:0] {
        RC_IDLE  = 2'd0,
        RC_READ  = 2'd1,
        RC_DRAIN = 2'd2
    } rc_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [SLOT_W-1:0]  slot,
                                                    input logic [SLOT_AW-1:0] idx);
        return {{(ADDR_W - SLOT_W - SLOT_AW){1'b0}}, slot, idx};
    endfunction

endpackage

// File: rtl/library_slot_table.sv
// Per-slot validity and length bookkeeping plus the allocation write pointer.
// Port "wp" always looks at the allocation slot; port "rd" looks at any slot.
module library_slot_table
    import library_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_i,
    input  logic              close_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] wp_o,
    output logic              wp_valid_o,
    output logic [LEN_W-1:0]  wp_len_o,
    input  logic [SLOT_W-1:0] rd_slot_i,
    output logic              rd_valid_o,
    output logic [LEN_W-1:0]  rd_len_o
);

    logic [SLOT_W-1:0] wp_q;
    logic [SLOT_W-1:0] wp_d;
    logic [N_SLOT-1:0] valid_all;
    logic [LEN_W-1:0]  len_all [N_SLOT];
    logic              rd_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
            logic             sel;
            logic             valid_q;
            logic [LEN_W-1:0] len_q;

            assign sel = (wp_q == SLOT_W'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    len_q   <= '0;
                end else if (sel) begin
                    if (alloc_i) begin
                        valid_q <= 1'b0;
                        len_q   <= '0;
                    end else begin
                        if (inc_i)   len_q   <= len_q + LEN_W'(1);
                        if (close_i) valid_q <= 1'b1;
                    end
                end
            end

            assign valid_all[gi] = valid_q;
            assign len_all[gi]   = len_q;
        end
    endgenerate

    // The pointer only moves when a recording closes, so it names the slot in use.
    always_comb begin
        wp_d = wp_q;
        if (close_i) begin
            wp_d = (wp_q == SLOT_W'(N_SLOT - 1)) ? '0 : wp_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wp_q <= '0;
        else         wp_q <= wp_d;
    end

    assign wp_o        = wp_q;
    assign wp_valid_o  = valid_all[wp_q];
    assign wp_len_o    = len_all[wp_q];
    assign rd_in_range = (rd_slot_i < SLOT_W'(N_SLOT));
    assign rd_valid_o  = rd_in_range && valid_all[rd_slot_i];
    assign rd_len_o    = rd_in_range ? len_all[rd_slot_i] : '0;

endmodule

// File: rtl/library_slot_arbiter.sv
// Shares the single-port library SRAM between the store stream (strict
// priority) and slot replay, which fills the cycles the store leaves idle.
module library_slot_arbiter
    import library_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_st_start,
    input  logic              i_st_valid,
    input  logic [4:0]        i_st_x,
    input  logic [4:0]        i_st_y,
    input  logic              i_st_end,
    output logic [4:0]        o_st_slot,
    output logic              o_st_ovw,
    input  logic              i_rc_req,
    input  logic [4:0]        i_rc_slot,
    output logic              o_rc_busy,
    output logic              o_rc_valid,
    output logic [4:0]        o_rc_x,
    output logic [4:0]        o_rc_y,
    output logic              o_rc_done,
    output logic              o_rc_err,
    output logic              o_mem_cen,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [9:0]        o_mem_wdata,
    input  logic [9:0]        i_mem_rdata
);

    st_state_e          st_state_q, st_state_d;
    logic [SLOT_W-1:0]  st_slot_q, st_slot_d;
    logic               ovw_q, ovw_d;
    rc_state_e          rc_state_q, rc_state_d;
    logic [SLOT_W-1:0]  rc_slot_q, rc_slot_d;
    logic [SLOT_AW-1:0] rd_idx_q, rd_idx_d;
    logic               rd_pend_q, rd_pend_d;
    logic               err_q, err_d;

    logic [SLOT_W-1:0]  wp;
    logic               wp_valid;
    logic [LEN_W-1:0]   wp_len;
    logic [SLOT_W-1:0]  tbl_rd_slot;
    logic               rd_valid;
    logic [LEN_W-1:0]   rd_len;

    logic st_alloc, st_wr, st_close;
    logic rc_abort, rc_reject, rec_hit, rd_last;
    logic rc_rd, rc_done;

    library_slot_table u_table (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .alloc_i    (st_alloc),
        .close_i    (st_close),
        .inc_i      (st_wr),
        .wp_o       (wp),
        .wp_valid_o (wp_valid),
        .wp_len_o   (wp_len),
        .rd_slot_i  (tbl_rd_slot),
        .rd_valid_o (rd_valid),
        .rd_len_o   (rd_len)
    );

    // While recording, wp is the slot being written; a full slot drops input.
    assign st_alloc = (st_state_q == ST_IDLE) && i_st_start;
    assign st_wr    = (st_state_q == ST_REC) && i_st_valid && !wp_len[SLOT_AW];
    assign st_close = (st_state_q == ST_REC) &&
                      (i_st_end || (st_wr && wp_len == LEN_W'((1 << SLOT_AW) - 1)));

    always_comb begin
        st_state_d = st_state_q;
        st_slot_d  = st_slot_q;
        ovw_d      = ovw_q;
        if (st_alloc) begin
            st_state_d = ST_REC;
            st_slot_d  = wp;
            ovw_d      = wp_valid;
        end else if (st_close) begin
            st_state_d = ST_IDLE;
        end
    end

    assign tbl_rd_slot = (rc_state_q == RC_IDLE) ? i_rc_slot : rc_slot_q;
    assign rec_hit     = ((st_state_q == ST_REC) || st_alloc) && (i_rc_slot == wp);
    assign rc_reject   = (i_rc_slot >= SLOT_W'(N_SLOT)) || !rd_valid || rec_hit;
    assign rc_abort    = st_alloc && (rc_state_q != RC_IDLE) && (wp == rc_slot_q);
    assign rd_last     = ({1'b0, rd_idx_q} == rd_len - LEN_W'(1));

    always_comb begin
        rc_state_d = rc_state_q;
        rc_slot_d  = rc_slot_q;
        rd_idx_d   = rd_idx_q;
        rd_pend_d  = 1'b0;
        err_d      = 1'b0;
        rc_rd      = 1'b0;
        rc_done    = 1'b0;
        case (rc_state_q)
            RC_IDLE: begin
                if (i_rc_req) begin
                    if (rc_reject) begin
                        err_d = 1'b1;
                    end else begin
                        rc_slot_d  = i_rc_slot;
                        rd_idx_d   = '0;
                        rc_state_d = (rd_len == '0) ? RC_DRAIN : RC_READ;
                    end
                end
            end
            RC_READ: begin
                if (!st_wr) begin
                    rc_rd     = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_idx_d  = rd_idx_q + SLOT_AW'(1);
                    if (rd_last) rc_state_d = RC_DRAIN;
                end
            end
            RC_DRAIN: begin
                rc_done    = 1'b1;
                rc_state_d = RC_IDLE;
            end
            default: rc_state_d = RC_IDLE;
        endcase
        // Re-recording the replayed slot kills the replay and any pending read.
        if (rc_abort) begin
            rc_state_d = RC_IDLE;
            rc_rd      = 1'b0;
            rd_pend_d  = 1'b0;
            rc_done    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_state_q <= ST_IDLE;
            st_slot_q  <= '0;
            ovw_q      <= 1'b0;
            rc_state_q <= RC_IDLE;
            rc_slot_q  <= '0;
            rd_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st_state_q <= st_state_d;
            st_slot_q  <= st_slot_d;
            ovw_q      <= ovw_d;
            rc_state_q <= rc_state_d;
            rc_slot_q  <= rc_slot_d;
            rd_idx_q   <= rd_idx_d;
            rd_pend_q  <= rd_pend_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        o_mem_cen   = st_wr | rc_rd;
        o_mem_wen   = st_wr;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (st_wr) begin
            o_mem_addr  = pack_addr(wp, wp_len[SLOT_AW-1:0]);
            o_mem_wdata = {i_st_x, i_st_y};
        end else if (rc_rd) begin
            o_mem_addr = pack_addr(rc_slot_q, rd_idx_q);
        end
    end

    assign o_st_slot        = st_slot_q;
    assign o_st_ovw         = (st_state_q == ST_REC) && ovw_q;
    assign o_rc_busy        = (rc_state_q != RC_IDLE);
    assign o_rc_valid       = rd_pend_q && !rc_abort;
    assign {o_rc_x, o_rc_y} = o_rc_valid ? i_mem_rdata : '0;
    assign o_rc_done        = rc_done;
    assign o_rc_err         = err_q;

endmodule

// File: tb/tb_library_slot_arbiter.sv
// Scenario bench for library_slot_arbiter: a behavioural SRAM, a per-slot golden
// model of recorded content and a queue of expected replay coordinates.
module tb_library_slot_arbiter;

    logic        clk = 1'b0;
    logic        i_rst_n, i_st_start, i_st_valid, i_st_end, i_rc_req;
    logic [4:0]  i_st_x, i_st_y, i_rc_slot;
    logic [4:0]  o_st_slot, o_rc_x, o_rc_y;
    logic        o_st_ovw, o_rc_busy, o_rc_valid, o_rc_done, o_rc_err, o_mem_cen, o_mem_wen;
    logic [19:0] o_mem_addr;
    logic [9:0]  o_mem_wdata;
    logic [9:0]  mem_rdata = '0;
    logic [9:0]  mem [32768];

    logic        s_cen, s_wen, s_busy, s_valid, s_done, s_err, s_ovw;
    logic [19:0] s_addr;
    logic [9:0]  s_wdata;
    logic [4:0]  s_x, s_y, s_slot;

    int          n_checks = 0;
    int          n_err = 0;
    int          wp_m = 0;
    bit          gold_valid [26];
    int          gold_len [26];
    logic [9:0]  gold_d [26][1024];
    logic [9:0]  exp_q [$];

    library_slot_arbiter dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_st_start(i_st_start), .i_st_valid(i_st_valid), .i_st_x(i_st_x), .i_st_y(i_st_y),
        .i_st_end(i_st_end), .o_st_slot(o_st_slot), .o_st_ovw(o_st_ovw),
        .i_rc_req(i_rc_req), .i_rc_slot(i_rc_slot), .o_rc_busy(o_rc_busy),
        .o_rc_valid(o_rc_valid), .o_rc_x(o_rc_x), .o_rc_y(o_rc_y),
        .o_rc_done(o_rc_done), .o_rc_err(o_rc_err),
        .o_mem_cen(o_mem_cen), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_cen) begin
            if (o_mem_wen) mem[o_mem_addr[14:0]] <= o_mem_wdata;
            else           mem_rdata <= mem[o_mem_addr[14:0]];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] exp_addr(input int slot, input int idx);
        return {5'b0, slot[4:0], idx[9:0]};
    endfunction

    // Snapshot all outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc();
        @(negedge clk);
        s_cen = o_mem_cen;  s_wen = o_mem_wen;   s_addr = o_mem_addr; s_wdata = o_mem_wdata;
        s_busy = o_rc_busy; s_valid = o_rc_valid; s_x = o_rc_x;       s_y = o_rc_y;
        s_done = o_rc_done; s_err = o_rc_err;     s_slot = o_st_slot;  s_ovw = o_st_ovw;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        wp_m = 0;
        for (int s = 0; s < 26; s++) begin
            gold_valid[s] = 1'b0;
            gold_len[s]   = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_record(input int n, input bit end_with_last);
        int         slot;
        int         nwr;
        bit         exp_ovw;
        logic [9:0] d;
        slot = wp_m; exp_ovw = gold_valid[slot]; nwr = 0;
        i_st_start = 1'b1;
        cyc();
        i_st_start = 1'b0;
        n_checks++;
        if (s_cen !== 1'b0) begin
            n_err++; $display("FAIL alloc_noacc: cen=%b required 0", s_cen);
        end
        gold_valid[slot] = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = 10'($urandom);
            {i_st_x, i_st_y} = d;
            i_st_valid = 1'b1;
            i_st_end   = end_with_last && (i == n - 1);
            cyc();
            if (i == 0) begin
                n_checks++;
                if ({s_slot, s_ovw} !== {slot[4:0], exp_ovw}) begin
                    n_err++; $display("FAIL st_slot_ovw: slot=%0d ovw=%b required slot=%0d ovw=%b", s_slot, s_ovw, slot, exp_ovw);
                end
            end
            n_checks++;
            if (i < 1024) begin
                if ({s_cen, s_wen, s_addr, s_wdata} !== {2'b11, exp_addr(slot, i), d}) begin
                    n_err++; $display("FAIL st_write: cen=%b wen=%b addr=%h data=%h required addr=%h data=%h", s_cen, s_wen, s_addr, s_wdata, exp_addr(slot, i), d);
                end
                gold_d[slot][i] = d;
                nwr++;
            end else if (s_cen !== 1'b0) begin
                n_err++; $display("FAIL st_drop: cen=%b addr=%h required no access", s_cen, s_addr);
            end
        end
        i_st_valid = 1'b0; i_st_end = 1'b0; i_st_x = '0; i_st_y = '0;
        if (!(end_with_last && n > 0) && n < 1024) begin
            i_st_end = 1'b1;
            cyc();
            i_st_end = 1'b0;
            if (n == 0) begin
                n_checks++;
                if ({s_slot, s_ovw} !== {slot[4:0], exp_ovw}) begin
                    n_err++; $display("FAIL st_slot_ovw: slot=%0d ovw=%b required slot=%0d ovw=%b", s_slot, s_ovw, slot, exp_ovw);
                end
            end
        end
        gold_valid[slot] = 1'b1;
        gold_len[slot]   = nwr;
        wp_m = (wp_m == 25) ? 0 : wp_m + 1;
        $display("record slot=%0d valids=%0d writes=%0d ovw=%b", slot, n, nwr, exp_ovw);
    endtask

    task automatic do_replay(input int slot);
        int         len;
        int         nval;
        bit         done_seen;
        logic [9:0] e;
        len = gold_len[slot]; nval = 0; done_seen = 1'b0;
        for (int i = 0; i < len; i++) exp_q.push_back(gold_d[slot][i]);
        i_rc_req = 1'b1; i_rc_slot = 5'(slot);
        cyc();
        i_rc_req = 1'b0;
        for (int k = 1; k <= len + 3 && !done_seen; k++) begin
            cyc();
            if (k == 1) begin
                n_checks++;
                if (s_err !== 1'b0) begin
                    n_err++; $display("FAIL rc_noerr: err=%b required 0", s_err);
                end
            end
            if (k <= len) begin
                n_checks++;
                if ({s_cen, s_wen, s_addr} !== {2'b10, exp_addr(slot, k - 1)}) begin
                    n_err++; $display("FAIL rc_read: cen=%b wen=%b addr=%h required read of %h", s_cen, s_wen, s_addr, exp_addr(slot, k - 1));
                end
            end
            if (s_valid === 1'b1) begin
                nval++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rc_extra: data=%h required no data", {s_x, s_y});
                end else begin
                    e = exp_q.pop_front();
                    if ({s_x, s_y} !== e) begin
                        n_err++; $display("FAIL rc_data: data=%h required %h", {s_x, s_y}, e);
                    end
                end
            end
            if (s_done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++;
                if (k != len + 1 || s_valid !== (len > 0)) begin
                    n_err++; $display("FAIL rc_done: at cycle %0d valid=%b required cycle %0d valid=%b", k, s_valid, len + 1, (len > 0));
                end
            end
        end
        n_checks++;
        if (!done_seen || nval != len || exp_q.size() != 0) begin
            n_err++; $display("FAIL rc_complete: done=%b count=%0d required done=1 count=%0d", done_seen, nval, len);
        end
        exp_q.delete();
        $display("replay slot=%0d len=%0d data=%0d", slot, len, nval);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_st_start = 1'b0; i_st_valid = 1'b0; i_st_end = 1'b0;
        i_st_x = '0; i_st_y = '0; i_rc_req = 1'b0; i_rc_slot = '0;
        model_reset();
        cyc();
        n_checks++;
        if ({s_cen, s_wen, s_addr, s_wdata, s_busy, s_valid, s_x, s_y, s_done, s_err, s_slot, s_ovw} !== '0) begin
            n_err++; $display("FAIL reset_outputs: cen=%b addr=%h busy=%b valid=%b done=%b err=%b slot=%0d required all 0", s_cen, s_addr, s_busy, s_valid, s_done, s_err, s_slot);
        end
        i_rst_n = 1'b1;
        cyc();
        n_checks++;
        if ({s_cen, s_busy, s_err, s_slot, s_ovw} !== '0) begin
            n_err++; $display("FAIL reset_idle: cen=%b busy=%b err=%b slot=%0d required all 0", s_cen, s_busy, s_err, s_slot);
        end
        $display("reset applied and released");
    endtask

    task automatic test_record_replay();
        do_record(5, 1'b0);
        do_replay(0);
    endtask

    task automatic test_contention();
        int         slot_w;
        int         rd;
        int         c;
        bit         done_seen;
        logic [9:0] d;
        logic [9:0] e;
        slot_w = wp_m; rd = 0; c = 0; done_seen = 1'b0; d = '0;
        for (int i = 0; i < gold_len[0]; i++) exp_q.push_back(gold_d[0][i]);
        i_rc_req = 1'b1; i_rc_slot = 5'd0; i_st_start = 1'b1;
        cyc();
        i_rc_req = 1'b0; i_st_start = 1'b0;
        n_checks++;
        if (s_cen !== 1'b0) begin
            n_err++; $display("FAIL cont_start_noacc: cen=%b required 0", s_cen);
        end
        gold_valid[slot_w] = 1'b0;
        while (!done_seen && c < 40) begin
            if (c < 8) begin
                d = 10'($urandom);
                {i_st_x, i_st_y} = d;
                i_st_valid = 1'b1;
            end else begin
                i_st_valid = 1'b0;
                i_st_end   = (c == 8);
            end
            cyc();
            n_checks++;
            if (c < 8) begin
                if ({s_cen, s_wen, s_addr, s_wdata} !== {2'b11, exp_addr(slot_w, c), d}) begin
                    n_err++; $display("FAIL cont_write: cen=%b wen=%b addr=%h required write %h", s_cen, s_wen, s_addr, exp_addr(slot_w, c));
                end
                gold_d[slot_w][c] = d;
            end else if (rd < gold_len[0]) begin
                if ({s_cen, s_wen, s_addr} !== {2'b10, exp_addr(0, rd)}) begin
                    n_err++; $display("FAIL cont_read: cen=%b wen=%b addr=%h required read %h", s_cen, s_wen, s_addr, exp_addr(0, rd));
                end
                rd++;
            end else if (s_cen !== 1'b0) begin
                n_err++; $display("FAIL cont_idle: cen=%b required 0", s_cen);
            end
            if (s_valid === 1'b1) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
                if ({s_x, s_y} !== e || c < 9) begin
                    n_err++; $display("FAIL cont_data: cycle=%0d data=%h required %h after recording", c, {s_x, s_y}, e);
                end
            end
            if (s_done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++;
                if (rd != gold_len[0] || s_valid !== 1'b1 || exp_q.size() != 0) begin
                    n_err++; $display("FAIL cont_done: reads=%0d valid=%b left=%0d required reads=%0d valid=1 left=0", rd, s_valid, exp_q.size(), gold_len[0]);
                end
            end
            c++;
        end
        i_st_valid = 1'b0; i_st_end = 1'b0; i_st_x = '0; i_st_y = '0;
        n_checks++;
        if (!done_seen) begin
            n_err++; $display("FAIL cont_timeout: done=0 required done within 40 cycles");
        end
        exp_q.delete();
        gold_valid[slot_w] = 1'b1; gold_len[slot_w] = 8;
        wp_m = (wp_m == 25) ? 0 : wp_m + 1;
        $display("contention record slot=%0d len=8 with replay slot=0 reads=%0d", slot_w, rd);
    endtask

    task automatic test_full_slot();
        int slot;
        slot = wp_m;
        do_record(1030, 1'b0);
        n_checks++;
        if (gold_len[slot] != 1024) begin
            n_err++; $display("FAIL full_len: writes=%0d required 1024", gold_len[slot]);
        end
        do_replay(slot);
    endtask

    task automatic test_errors();
        int cases [4];
        int s;
        bit rec;
        cases = '{10, 26, 31, -1};
        for (int c = 0; c < 4; c++) begin
            s = cases[c];
            rec = (s < 0);
            if (rec) begin
                i_st_start = 1'b1;
                cyc();
                i_st_start = 1'b0;
                s = wp_m;
            end
            i_rc_req = 1'b1; i_rc_slot = 5'(s);
            cyc();
            i_rc_req = 1'b0;
            n_checks++;
            if (s_cen !== 1'b0) begin
                n_err++; $display("FAIL err_req_noacc: slot=%0d cen=%b required 0", s, s_cen);
            end
            cyc();
            n_checks++;
            if ({s_err, s_busy, s_cen} !== 3'b100) begin
                n_err++; $display("FAIL err_pulse: slot=%0d err=%b busy=%b cen=%b required 1 0 0", s, s_err, s_busy, s_cen);
            end
            cyc();
            n_checks++;
            if ({s_err, s_cen} !== 2'b00) begin
                n_err++; $display("FAIL err_single: slot=%0d err=%b cen=%b required 0 0", s, s_err, s_cen);
            end
            if (rec) begin
                i_st_end = 1'b1;
                cyc();
                i_st_end = 1'b0;
                gold_valid[s] = 1'b1; gold_len[s] = 0;
                wp_m = (wp_m == 25) ? 0 : wp_m + 1;
            end
            $display("rejected request slot=%0d recording=%b", s, rec);
        end
    endtask

    task automatic test_wrap();
        while (wp_m != 0) do_record(2, (wp_m % 2) == 1);
        do_replay(7);
        do_record(3, 1'b0);
        do_replay(0);
        do_replay(3);
    endtask

    task automatic test_reset_mid_replay();
        i_rc_req = 1'b1; i_rc_slot = 5'd2;
        cyc();
        i_rc_req = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if ({s_busy, s_valid} !== 2'b11) begin
            n_err++; $display("FAIL pre_reset_busy: busy=%b valid=%b required 1 1", s_busy, s_valid);
        end
        i_rst_n = 1'b0;
        cyc();
        n_checks++;
        if ({s_cen, s_wen, s_addr, s_wdata, s_busy, s_valid, s_x, s_y, s_done, s_err, s_slot, s_ovw} !== '0) begin
            n_err++; $display("FAIL midrst_outputs: cen=%b addr=%h busy=%b valid=%b done=%b slot=%0d required all 0", s_cen, s_addr, s_busy, s_valid, s_done, s_slot);
        end
        i_rst_n = 1'b1;
        model_reset();
        $display("reset asserted mid-replay");
        i_rc_req = 1'b1; i_rc_slot = 5'd0;
        cyc();
        i_rc_req = 1'b0;
        cyc();
        n_checks++;
        if ({s_err, s_busy} !== 2'b10) begin
            n_err++; $display("FAIL post_rst_err: err=%b busy=%b required 1 0", s_err, s_busy);
        end
        $display("rejected request slot=0 after reset");
        do_record(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_record_replay();
        test_contention();
        test_full_slot();
        test_errors();
        test_wrap();
        test_reset_mid_replay();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
